// File: rtl/tst_chk_pkg.sv
// Shared types and defaults for the host-to-FPGA test-data checker.
// The counter helper is shared by the top-level statistics path.
package tst_chk_pkg;

    localparam int TST_CHK_FIFO_AW = 4;
    localparam int TST_CHK_ERR_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            sat_inc32 = val;
        end else begin
            sat_inc32 = val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/tst_chk_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head word whenever empty is low.
// Flush empties the FIFO and takes priority over a simultaneous push or pop.
module tst_chk_fifo #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_s;
    logic          full_r;
    logic          push_s;
    logic          pop_s;

    // Qualify push/pop and derive the next occupancy.
    always_comb begin
        push_s = wr_en & ~full_r & ~flush;
        pop_s  = rd_en & (count_r != '0) & ~flush;
        if (flush) begin
            count_s = '0;
        end else if (push_s && !pop_s) begin
            count_s = count_r + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            count_s = count_r - (AW+1)'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
        end else begin
            count_r <= count_s;
            full_r  <= (count_s == (AW+1)'(DEPTH));
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
            end
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = (count_r == '0);

endmodule

// File: rtl/tst_data_checker.sv
// Receives host words, buffers them and checks an incrementing-counter pattern,
// keeping word/error counts and the first mismatch for readback.
module tst_data_checker
    import tst_chk_pkg::*;
#(
    parameter int FIFO_AW = TST_CHK_FIFO_AW,
    parameter int ERR_W   = TST_CHK_ERR_W
) (
    input  logic             bus_clk,
    input  logic             reset_n,
    input  logic             user_w_write_32_open,
    input  logic             user_w_write_32_wren,
    input  logic [31:0]      user_w_write_32_data,
    output logic             user_w_write_32_full,
    input  logic             chk_enable,
    input  logic             chk_clear,
    output logic [1:0]       chk_state,
    output logic [31:0]      chk_word_count,
    output logic [ERR_W-1:0] chk_err_count,
    output logic [31:0]      chk_first_exp,
    output logic [31:0]      chk_first_got,
    output logic [31:0]      chk_first_idx,
    output logic             chk_overflow,
    output logic             led_active,
    output logic             led_error
);

    chk_state_e       state_r;
    chk_state_e       state_s;
    logic             open_q_r;
    logic             rise_s;
    logic             fall_s;
    logic             active_s;
    logic             enter_sync_s;
    logic             enter_done_s;
    logic             flush_s;
    logic             push_s;
    logic             pop_s;
    logic             mismatch_s;
    logic [31:0]      fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [31:0]      expected_r;
    logic [31:0]      word_count_r;
    logic [ERR_W-1:0] err_count_r;
    logic [31:0]      first_exp_r;
    logic [31:0]      first_got_r;
    logic [31:0]      first_idx_r;
    logic             overflow_r;

    // Single registered copy of open for edge detection; reset low so an
    // already-open file is seen as a rising edge on the first clock.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            open_q_r <= 1'b0;
        end else begin
            open_q_r <= user_w_write_32_open;
        end
    end

    // Event decode; chk_clear outranks open edges, and any flush blocks push/pop.
    always_comb begin
        rise_s       = user_w_write_32_open & ~open_q_r;
        fall_s       = ~user_w_write_32_open & open_q_r;
        active_s     = (state_r == ST_SYNC) || (state_r == ST_CHECK);
        enter_sync_s = ~chk_clear & rise_s & ((state_r == ST_IDLE) || (state_r == ST_DONE));
        enter_done_s = ~chk_clear & fall_s & active_s;
        flush_s      = chk_clear | enter_sync_s | enter_done_s;
        push_s       = user_w_write_32_wren & ~flush_s;
        pop_s        = ~fifo_empty_s & chk_enable & active_s & ~flush_s;
        mismatch_s   = (fifo_dout_s != expected_r);
    end

    tst_chk_fifo #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk   (bus_clk),
        .rst_n (reset_n),
        .flush (flush_s),
        .din   (user_w_write_32_data),
        .wr_en (push_s),
        .rd_en (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        if (chk_clear) begin
            state_s = user_w_write_32_open ? ST_SYNC : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = rise_s ? ST_SYNC : ST_IDLE;
                ST_SYNC: begin
                    if (fall_s) begin
                        state_s = ST_DONE;
                    end else if (pop_s) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_SYNC;
                    end
                end
                ST_CHECK: state_s = fall_s ? ST_DONE : ST_CHECK;
                ST_DONE:  state_s = rise_s ? ST_SYNC : ST_DONE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Comparator and statistics; a mismatch resyncs expected to the received word.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            expected_r   <= 32'd0;
            word_count_r <= 32'd0;
            err_count_r  <= '0;
            first_exp_r  <= 32'd0;
            first_got_r  <= 32'd0;
            first_idx_r  <= 32'd0;
        end else if (chk_clear || enter_sync_s) begin
            expected_r   <= 32'd0;
            word_count_r <= 32'd0;
            err_count_r  <= '0;
            first_exp_r  <= 32'd0;
            first_got_r  <= 32'd0;
            first_idx_r  <= 32'd0;
        end else if (pop_s) begin
            word_count_r <= sat_inc32(word_count_r);
            if (state_r == ST_SYNC || mismatch_s) begin
                expected_r <= fifo_dout_s + 32'd1;
            end else begin
                expected_r <= expected_r + 32'd1;
            end
            if (state_r == ST_CHECK && mismatch_s) begin
                if (err_count_r != {ERR_W{1'b1}}) begin
                    err_count_r <= err_count_r + ERR_W'(1);
                end
                if (err_count_r == '0) begin
                    first_exp_r <= expected_r;
                    first_got_r <= fifo_dout_s;
                    first_idx_r <= word_count_r;
                end
            end
        end
    end

    // Sticky overflow; a word dropped by chk_clear does not count.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (chk_clear) begin
            overflow_r <= 1'b0;
        end else if (user_w_write_32_wren && fifo_full_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Output decode from registered state and counts.
    always_comb begin
        chk_state            = state_r;
        chk_word_count       = word_count_r;
        chk_err_count        = err_count_r;
        chk_first_exp        = first_exp_r;
        chk_first_got        = first_got_r;
        chk_first_idx        = first_idx_r;
        chk_overflow         = overflow_r;
        user_w_write_32_full = fifo_full_s;
        led_active           = (state_r == ST_CHECK);
        led_error            = (err_count_r != '0);
    end

endmodule

// File: tb/tb_tst_data_checker.sv
// Self-checking bench for tst_data_checker: a reference model queues the expected
// counts per word sent, and a monitor compares them as the DUT consumes words.
module tb_tst_data_checker;

    logic        bus_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        open_i  = 1'b0;
    logic        wren    = 1'b0;
    logic [31:0] data    = 32'd0;
    logic        full;
    logic        enable  = 1'b0;
    logic        clear   = 1'b0;
    logic [1:0]  state;
    logic [31:0] word_count;
    logic [15:0] err_count;
    logic [31:0] first_exp;
    logic [31:0] first_got;
    logic [31:0] first_idx;
    logic        overflow;
    logic        led_active;
    logic        led_error;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [31:0] wc;
        logic [31:0] ec;
    } sb_t;
    sb_t sb[$];

    logic        m_sync;
    logic [31:0] m_exp;
    logic [31:0] m_wc;
    logic [31:0] m_ec;
    logic [31:0] prev_wc = 32'd0;

    tst_data_checker dut (
        .bus_clk              (bus_clk),
        .reset_n              (reset_n),
        .user_w_write_32_open (open_i),
        .user_w_write_32_wren (wren),
        .user_w_write_32_data (data),
        .user_w_write_32_full (full),
        .chk_enable           (enable),
        .chk_clear            (clear),
        .chk_state            (state),
        .chk_word_count       (word_count),
        .chk_err_count        (err_count),
        .chk_first_exp        (first_exp),
        .chk_first_got        (first_got),
        .chk_first_idx        (first_idx),
        .chk_overflow         (overflow),
        .led_active           (led_active),
        .led_error            (led_error)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = 1'b1;
        m_exp  = 32'd0;
        m_wc   = 32'd0;
        m_ec   = 32'd0;
    endtask

    // Reference behaviour of the pattern checker for one consumed word.
    task automatic model_push(input logic [31:0] w);
        sb_t e;
        if (m_sync) begin
            m_sync = 1'b0;
            m_exp  = w + 32'd1;
        end else if (w != m_exp) begin
            m_ec  = m_ec + 32'd1;
            m_exp = w + 32'd1;
        end else begin
            m_exp = m_exp + 32'd1;
        end
        m_wc = m_wc + 32'd1;
        e.wc = m_wc;
        e.ec = m_ec;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    // Drive one word for one cycle; accepted words feed the model.
    task automatic send(input logic [31:0] w, input bit accepted);
        wren = 1'b1;
        data = w;
        if (accepted) model_push(w);
        tick();
        wren = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
        model_reset();
    endtask

    task automatic drain();
        int budget = 400;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        tick();
        check_eq("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: each change of the word count to a nonzero value is one consumed word.
    always @(negedge bus_clk) begin
        if (word_count != prev_wc) begin
            if (word_count != 32'd0) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_pop", word_count, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check_eq("sb_word_count", word_count, e.wc);
                    check_eq("sb_err_count", 32'(err_count), e.ec);
                end
            end
            prev_wc = word_count;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_wc", word_count, 32'd0);
        reset_n = 1'b1;
        tick();
        check_eq("idle_hold", 32'(state), 32'd0);

        // Clean stream
        open_i = 1'b1;
        tick();
        check_eq("open_sync", 32'(state), 32'd1);
        tick();
        model_reset();
        enable = 1'b1;
        for (int i = 0; i < 256; i++) send(32'h5 + 32'(i), 1'b1);
        drain();
        check_eq("clean_wc", word_count, 32'd256);
        check_eq("clean_ec", 32'(err_count), 32'd0);
        check_eq("clean_state", 32'(state), 32'd2);
        check_eq("clean_led_active", 32'(led_active), 32'd1);
        check_eq("clean_full", 32'(full), 32'd0);

        // Wrap through 0xFFFFFFFF
        pulse_clear();
        check_eq("clear_sync", 32'(state), 32'd1);
        send(32'hFFFF_FFFE, 1'b1);
        send(32'hFFFF_FFFF, 1'b1);
        send(32'h0000_0000, 1'b1);
        send(32'h0000_0001, 1'b1);
        drain();
        check_eq("wrap_wc", word_count, 32'd4);
        check_eq("wrap_ec", 32'(err_count), 32'd0);

        // Single corruption
        pulse_clear();
        send(32'd0, 1'b1);
        send(32'd1, 1'b1);
        send(32'd2, 1'b1);
        send(32'h77, 1'b1);
        send(32'h78, 1'b1);
        drain();
        check_eq("corr_ec", 32'(err_count), 32'd1);
        check_eq("corr_first_exp", first_exp, 32'd3);
        check_eq("corr_first_got", first_got, 32'h77);
        check_eq("corr_first_idx", first_idx, 32'd3);
        check_eq("corr_wc", word_count, 32'd5);
        check_eq("corr_led_error", 32'(led_error), 32'd1);

        // Backpressure
        enable = 1'b0;
        pulse_clear();
        check_eq("clr_first_got", first_got, 32'd0);
        for (int i = 0; i < 16; i++) begin
            send(32'(i), 1'b1);
            if (i == 14) check_eq("bp_not_full_15", 32'(full), 32'd0);
        end
        check_eq("bp_full_16", 32'(full), 32'd1);
        check_eq("bp_no_ovf_yet", 32'(overflow), 32'd0);
        send(32'd16, 1'b0);
        check_eq("bp_overflow", 32'(overflow), 32'd1);
        check_eq("bp_wc_stalled", word_count, 32'd0);
        enable = 1'b1;
        tick();
        check_eq("bp_full_clears", 32'(full), 32'd0);
        drain();
        check_eq("bp_wc", word_count, 32'd16);
        check_eq("bp_ec", 32'(err_count), 32'd0);

        // Close and reopen
        pulse_clear();
        check_eq("clr_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) send(32'h100 + 32'(i), 1'b1);
        drain();
        open_i = 1'b0;
        tick();
        tick();
        check_eq("close_done", 32'(state), 32'd3);
        check_eq("close_wc_hold", word_count, 32'd10);
        check_eq("close_full", 32'(full), 32'd0);
        open_i = 1'b1;
        tick();
        check_eq("reopen_sync", 32'(state), 32'd1);
        check_eq("reopen_wc", word_count, 32'd0);
        tick();
        model_reset();

        // chk_clear mid-stream with wren high
        for (int i = 0; i < 5; i++) send(32'(i), 1'b1);
        wren  = 1'b1;
        data  = 32'd5;
        clear = 1'b1;
        tick();
        wren  = 1'b0;
        clear = 1'b0;
        sb.delete();
        model_reset();
        check_eq("mclr_wc", word_count, 32'd0);
        check_eq("mclr_state", 32'(state), 32'd1);
        tick();
        tick();
        check_eq("mclr_dropped", word_count, 32'd0);
        send(32'd8, 1'b1);
        send(32'd9, 1'b1);
        drain();
        check_eq("mclr_resume_wc", word_count, 32'd2);
        check_eq("mclr_resume_ec", 32'(err_count), 32'd0);

        // Asynchronous reset mid-cycle
        send(32'd10, 1'b1);
        send(32'd50, 1'b1);
        drain();
        check_eq("pre_rst_led_error", 32'(led_error), 32'd1);
        @(posedge bus_clk);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_wc", word_count, 32'd0);
        check_eq("arst_ec", 32'(err_count), 32'd0);
        check_eq("arst_first_exp", first_exp, 32'd0);
        check_eq("arst_first_got", first_got, 32'd0);
        check_eq("arst_first_idx", first_idx, 32'd0);
        check_eq("arst_led", 32'({led_active, led_error, overflow, full}), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("arst_open_sync", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
